// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the CPU/RAM arbitration slice: arbiter state encoding
// and the default RAM address width.
package ram_arbiter_pkg;

  localparam int unsigned RAM_ADDR_W = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Two-way round-robin selector: picks the single requester, or the port that
// did not win last time when both request.
module rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic valid,
  output logic pick
);

  always_comb begin
    valid = req0 | req1;
    if (req0 && req1) pick = ~last_gnt;
    else              pick = req1;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port RAM arbiter with round-robin sharing, locked bursts bounded by
// MAX_BURST, and a fixed one-cycle read-return path per port.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned SIZE      = RAM_ADDR_W,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            lock0,
  input  logic            we0,
  input  logic [SIZE-1:0] addr0,
  input  logic [31:0]     wdata0,
  input  logic            req1,
  input  logic            lock1,
  input  logic            we1,
  input  logic [SIZE-1:0] addr1,
  input  logic [31:0]     wdata1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            rvalid0,
  output logic            rvalid1,
  output logic [31:0]     rdata0,
  output logic [31:0]     rdata1,
  output logic            wrEn,
  output logic [SIZE-1:0] addr_toRAM,
  output logic [31:0]     data_toRAM,
  input  logic [31:0]     data_fromRAM
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  arb_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic       last_gnt_q, last_gnt_d;
  logic       rr_valid, rr_sel;

  rr_pick u_rr_pick (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt_q),
    .valid    (rr_valid),
    .pick     (rr_sel)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    cnt_inc    = cnt_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (rr_valid) begin
          if (rr_sel) begin
            gnt1 = 1'b1;
            if (lock1) begin
              state_d = OWN1;
              cnt_d   = 4'd1;
            end
          end else begin
            gnt0 = 1'b1;
            if (lock0) begin
              state_d = OWN0;
              cnt_d   = 4'd1;
            end
          end
        end
      end
      OWN0: begin
        if (req0) begin
          gnt0  = 1'b1;
          cnt_d = cnt_inc;
          if (!lock0 || cnt_inc == BURST_LIMIT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          // Owner went quiet: the other port may use this cycle, burst ends.
          gnt1    = req1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      OWN1: begin
        if (req1) begin
          gnt1  = 1'b1;
          cnt_d = cnt_inc;
          if (!lock1 || cnt_inc == BURST_LIMIT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          gnt0    = req0;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (gnt0)      last_gnt_d = 1'b0;
    else if (gnt1) last_gnt_d = 1'b1;

    // No access may reach the RAM during the reset cycle.
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end

    wrEn       = 1'b0;
    addr_toRAM = '0;
    data_toRAM = '0;
    if (gnt0) begin
      wrEn       = we0;
      addr_toRAM = addr0;
      data_toRAM = wdata0;
    end else if (gnt1) begin
      wrEn       = we1;
      addr_toRAM = addr1;
      data_toRAM = wdata1;
    end

    rdata0 = rvalid0 ? data_fromRAM : '0;
    rdata1 = rvalid1 ? data_fromRAM : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      rvalid0    <= gnt0 & ~we0;
      rvalid1    <= gnt1 & ~we1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a simple one-cycle-latency RAM model.
module tb_ram_arbiter;

  localparam int unsigned SIZE = 14;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0, lock0, we0, req1, lock1, we1;
  logic [SIZE-1:0] addr0, addr1;
  logic [31:0]     wdata0, wdata1;
  logic            gnt0, gnt1, rvalid0, rvalid1, wrEn;
  logic [31:0]     rdata0, rdata1, data_toRAM;
  logic [31:0]     data_fromRAM = '0;
  logic [SIZE-1:0] addr_toRAM;

  logic [31:0] mem [0:(1<<SIZE)-1];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  ram_arbiter #(.SIZE(SIZE), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .lock0        (lock0),
    .we0          (we0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .req1         (req1),
    .lock1        (lock1),
    .we1          (we1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .rvalid0      (rvalid0),
    .rvalid1      (rvalid1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .wrEn         (wrEn),
    .addr_toRAM   (addr_toRAM),
    .data_toRAM   (data_toRAM),
    .data_fromRAM (data_fromRAM)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wrEn) mem[addr_toRAM] <= data_toRAM;
    data_fromRAM <= mem[addr_toRAM];
  end

  function automatic logic [31:0] init_word(input int unsigned a);
    return 32'h1000_0000 + a;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".gnt"},    {30'd0, gnt0, gnt1}, 32'd0);
    check({tag, ".rvalid"}, {30'd0, rvalid0, rvalid1}, 32'd0);
    check({tag, ".wrEn"},   {31'd0, wrEn}, 32'd0);
    check({tag, ".addr"},   {18'd0, addr_toRAM}, 32'd0);
    check({tag, ".data"},   data_toRAM, 32'd0);
  endtask

  logic [5:0] burst_g0;

  initial begin
    for (int unsigned i = 0; i < (1 << SIZE); i++) mem[i] = init_word(i);
    burst_g0 = 6'b101111;

    rst = 1'b1;
    req0 = 1'b1; lock0 = 1'b0; we0 = 1'b0; addr0 = 14'd5; wdata0 = '0;
    req1 = 1'b1; lock1 = 1'b0; we1 = 1'b0; addr1 = 14'd9; wdata1 = '0;

    // Reset with both ports requesting: nothing may reach the RAM.
    step();
    settle();
    check_quiet("reset");

    // Contested reads alternate starting at port 0.
    step();
    rst = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      settle();
      check($sformatf("alt_gnt0[%0d]", k), {31'd0, gnt0}, {31'd0, k % 2 == 0});
      check($sformatf("alt_gnt1[%0d]", k), {31'd0, gnt1}, {31'd0, k % 2 == 1});
      check($sformatf("alt_addr[%0d]", k), {18'd0, addr_toRAM}, (k % 2 == 0) ? 32'd5 : 32'd9);
      check($sformatf("alt_rdata0[%0d]", k), rdata0, (k % 2 == 1) ? init_word(5) : 32'd0);
      check($sformatf("alt_rvalid1[%0d]", k), {31'd0, rvalid1}, {31'd0, k == 2});
      step();
    end

    // Port 1 writes, then port 0 reads the same word back.
    req0 = 1'b0;
    we1 = 1'b1; addr1 = 14'd3; wdata1 = 32'hDEADBEEF;
    settle();
    check("wr_gnt1", {31'd0, gnt1}, 32'd1);
    check("wr_wrEn", {31'd0, wrEn}, 32'd1);
    check("wr_addr", {18'd0, addr_toRAM}, 32'd3);
    check("wr_data", data_toRAM, 32'hDEADBEEF);
    check("wr_rdata1_prev", rdata1, init_word(9));
    step();
    req1 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; addr0 = 14'd3;
    settle();
    check("rd_gnt0", {31'd0, gnt0}, 32'd1);
    check("rd_wrEn", {31'd0, wrEn}, 32'd0);
    check("wr_no_rvalid1", {31'd0, rvalid1}, 32'd0);
    step();
    addr0 = 14'd5;
    settle();
    check("rd_rvalid0", {31'd0, rvalid0}, 32'd1);
    check("rd_rdata0", rdata0, 32'hDEADBEEF);
    step();
    // Back-to-back reads on port 0 return on consecutive cycles.
    addr0 = 14'd9;
    settle();
    check("b2b_rdata0_a", rdata0, init_word(5));
    step();
    req0 = 1'b0;
    settle();
    check("b2b_rdata0_b", rdata0, init_word(9));
    check("b2b_idle_gnt", {30'd0, gnt0, gnt1}, 32'd0);

    // One port-1 access so port 0 wins the next contested cycle.
    req1 = 1'b1;
    step();
    settle();
    check("pre_burst_gnt1", {31'd0, gnt1}, 32'd1);

    // Locked burst on port 0 is cut off after MAX_BURST grants.
    step();
    req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1; addr0 = 14'd5; addr1 = 14'd9;
    for (int unsigned k = 0; k < 6; k++) begin
      settle();
      check($sformatf("burst_gnt0[%0d]", k), {31'd0, gnt0}, {31'd0, burst_g0[k]});
      check($sformatf("burst_gnt1[%0d]", k), {31'd0, gnt1}, {31'd0, ~burst_g0[k]});
      step();
    end

    // Owner drops its request inside the burst: port 1 gets the cycle.
    req0 = 1'b0;
    settle();
    check("drop_gnt0", {31'd0, gnt0}, 32'd0);
    check("drop_gnt1", {31'd0, gnt1}, 32'd1);
    step();
    req0 = 1'b1; lock0 = 1'b0;
    settle();
    check("drop_idle_gnt0", {31'd0, gnt0}, 32'd1);
    step();

    // Reset in the second cycle of a port-1 burst abandons it.
    req0 = 1'b0; req1 = 1'b1; lock1 = 1'b1;
    settle();
    check("rb_gnt1", {31'd0, gnt1}, 32'd1);
    step();
    rst = 1'b1;
    settle();
    check("rb_rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    step();
    rst = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    settle();
    check("rb_after_gnt", {30'd0, gnt0, gnt1}, 32'd0);
    check("rb_after_rvalid1", {31'd0, rvalid1}, 32'd0);
    step();
    req0 = 1'b1; req1 = 1'b1;
    settle();
    check("rb_first_gnt0", {31'd0, gnt0}, 32'd1);
    step();
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Ten idle cycles; locks without requests must do nothing.
    lock0 = 1'b1; lock1 = 1'b1;
    for (int unsigned k = 0; k < 10; k++) begin
      settle();
      check_quiet($sformatf("idle[%0d]", k));
      step();
    end
    lock0 = 1'b0; lock1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    settle();
    check("post_idle_gnt1", {30'd0, gnt0, gnt1}, 32'd1);
    step();
    settle();
    check("post_idle_gnt0", {30'd0, gnt0, gnt1}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter SIZE, default 14, sets the RAM address width in bits.
REQ-002 Parameter MAX_BURST, default 4, sets the maximum consecutive grants under lock; legal range 2..15.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous and active-high (one clock; reset is synchronous and active-high).
REQ-005 reqN  input  1  port N (N=0,1) requests one RAM access this cycle.
REQ-006 lockN  input  1  port N asks to keep ownership for following cycles (burst).
REQ-007 weN  input  1  port N access is a write.
REQ-008 addrN  input  SIZE  port N word address.
REQ-009 wdataN  input  32  port N write data.
REQ-010 gntN  output  1  port N access issued to RAM this cycle (combinational).
REQ-011 rvalidN  output  1  read data for port N valid this cycle (registered).
REQ-012 rdataN  output  32  read data for port N; equals data_fromRAM while rvalidN=1, else 0.
REQ-013 wrEn  output  1  RAM write enable.
REQ-014 addr_toRAM  output  SIZE  RAM address.
REQ-015 data_toRAM  output  32  RAM write data.
REQ-016 data_fromRAM  input  32  RAM read data; valid the cycle after the address is presented.

Function
REQ-017 At most one of gnt0/gnt1 SHALL be high per cycle; gntN implies reqN.
REQ-018 When gntN=1: wrEn=weN, addr_toRAM=addrN, data_toRAM=wdataN (same cycle); when no grant: wrEn=0, addr_toRAM=0, data_toRAM=0.
REQ-019 States: IDLE, OWN0, OWN1; a 4-bit burst counter; a last_gnt register.
REQ-020 IDLE: single requester is granted; both requesting -> grant the port other than last_gnt.
REQ-021 Every grant SHALL update last_gnt to the granted port.
REQ-022 Grant to port N with lockN=1 from IDLE -> OWNN next cycle, counter=1.
REQ-023 OWNN: port N has absolute priority; if reqN=1 it is granted and counter increments; the other port is granted only if reqN=0.
REQ-024 OWNN exits to IDLE when reqN=0, lockN=0, or the grant that makes counter equal MAX_BURST occurs; exit takes effect next cycle and counter clears.
REQ-025 On release by counter limit, last_gnt=N, so the other port wins the next contested cycle.
REQ-026 rvalidN SHALL be high exactly one cycle after a cycle with gntN=1 and weN=0; writes never raise rvalidN.
REQ-027 Back-to-back reads by one port SHALL yield rvalid on consecutive cycles; read latency fixed at 1.
REQ-028 lockN with reqN=0 SHALL have no effect.

Reset
REQ-029 While rst=1: state=IDLE, counter=0, last_gnt=1, rvalid0=rvalid1=0, no grants, wrEn=0, addr_toRAM=0, data_toRAM=0.
REQ-030 Reset asserted mid-burst SHALL abandon the burst; the pending rvalid is dropped.
REQ-031 First contested cycle after reset SHALL grant port 0.

Structure
REQ-032 State encoding (IDLE/OWN0/OWN1) and the SIZE default SHALL live in a shared package used by the CPU and arbiter.
REQ-033 One sub-module is natural: rr_pick, a 2-way round-robin selector (req0, req1, last_gnt -> grant index); all else in ram_arbiter.
REQ-034 Next-state/output logic SHALL be a single combinational block with defaults assigned first; registers in one clocked block.

Verification
REQ-035 After reset, req0=req1=1, lock=0, both reads, addr0=5, addr1=9 -> grants alternate 0,1,0,1; rvalid follows each grant by 1 cycle with RAM[5]/RAM[9].
REQ-036 Port 1 write addr=3 data=32'hDEADBEEF, then port 0 read addr=3 -> wrEn=1 one cycle; rvalid0 next cycle with rdata0=32'hDEADBEEF.
REQ-037 Port 0 lock0=1 continuous with req1=1 continuous -> gnt0 for 4 cycles, then gnt1 once, then port 0 again.
REQ-038 In OWN0, req0 drops for one cycle while req1=1 -> gnt1 that cycle, state returns IDLE.
REQ-039 rst asserted in 2nd cycle of port-1 burst -> next cycle no grant, rvalid1=0; with both requesting afterwards, port 0 granted first.
REQ-040 No requests for 10 cycles -> wrEn, addr_toRAM, data_toRAM, gnt*, rvalid* all 0 throughout.
